// File: rtl/bus_arbiter.sv
// Round-robin shared-bus arbiter with a turnaround cycle between owners,
// plus a transaction watchdog that completes and flags unanswered accesses.
//
// state | meaning
// IDLE  | no owner; arbitrate among requesters on the next edge
// OWNED | master `own` holds the bus until it drops its request
module bus_arbiter #(
  parameter int MASTERS        = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [MASTERS-1:0] bus_req,
  output logic [MASTERS-1:0] bus_grant,
  input  logic [31:0]        addr_bus,
  input  logic               rd_bus,
  input  logic               wr_bus,
  input  logic               fc_bus,
  output logic               fc_timeout,
  output logic               bus_error,
  output logic [31:0]        err_addr,
  output logic [1:0]         err_master,
  input  logic               err_clr
);

  typedef enum logic {IDLE, OWNED} state_t;

  localparam logic [15:0] TMO      = 16'(TIMEOUT_CYCLES);
  localparam logic [15:0] TMO_M1   = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  LAST_RST = 2'(MASTERS - 1);

  state_t             state, state_nxt;
  logic [1:0]         own, own_nxt, last, last_nxt;
  logic [MASTERS-1:0] grant_nxt;
  logic [15:0]        wd, wd_nxt;
  logic [1:0]         pick;
  logic               pick_vld, own_req, strobe, fire;
  int                 best_off, off;

  // Lowest rotated offset from last+1 wins among the active requesters.
  always_comb begin
    pick     = 2'd0;
    pick_vld = |bus_req;
    best_off = MASTERS;
    off      = 0;
    own_req  = 1'b0;
    for (int j = 0; j < MASTERS; j++) begin
      off = (j + 2 * MASTERS - int'(last) - 1) % MASTERS;
      if (bus_req[j] && (off < best_off)) begin
        best_off = off;
        pick     = 2'(j);
      end
      if (own == 2'(j)) own_req = bus_req[j];
    end
  end

  always_comb begin
    state_nxt = state;
    own_nxt   = own;
    last_nxt  = last;
    grant_nxt = bus_grant;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt = OWNED;
          own_nxt   = pick;
          last_nxt  = pick;
          for (int j = 0; j < MASTERS; j++) grant_nxt[j] = (pick == 2'(j));
        end
      end
      OWNED: begin
        if (!own_req) begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Watchdog counts consecutive strobe cycles without completion; it
  // saturates at the limit so a stuck strobe produces a single pulse.
  always_comb begin
    strobe = rd_bus | wr_bus;
    fire   = (state == OWNED) && strobe && !fc_bus && (wd == TMO_M1);
    wd_nxt = wd;
    if ((state != OWNED) || (state_nxt != OWNED) || fc_bus || !strobe)
      wd_nxt = 16'd0;
    else if (wd < TMO)
      wd_nxt = wd + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      own        <= 2'd0;
      last       <= LAST_RST;
      bus_grant  <= '0;
      wd         <= 16'd0;
      fc_timeout <= 1'b0;
      bus_error  <= 1'b0;
      err_addr   <= 32'd0;
      err_master <= 2'd0;
    end else begin
      state      <= state_nxt;
      own        <= own_nxt;
      last       <= last_nxt;
      bus_grant  <= grant_nxt;
      wd         <= wd_nxt;
      fc_timeout <= fire;
      if (fire) begin
        bus_error  <= 1'b1;
        err_addr   <= addr_bus;
        err_master <= own;
      end else if (err_clr) begin
        bus_error  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and randomized checks of bus_arbiter against a behavioural
// owner/timer model derived from the arbitration and watchdog rules.
module tb_bus_arbiter;
  localparam int M = 2;
  localparam int T = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [M-1:0] bus_req = '0;
  logic [M-1:0] bus_grant;
  logic [31:0]  addr_bus = 32'd0;
  logic         rd_bus = 1'b0, wr_bus = 1'b0, fc_bus = 1'b0, err_clr = 1'b0;
  logic         fc_timeout, bus_error;
  logic [31:0]  err_addr;
  logic [1:0]   err_master;

  bus_arbiter #(.MASTERS(M), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .bus_req(bus_req), .bus_grant(bus_grant),
    .addr_bus(addr_bus), .rd_bus(rd_bus), .wr_bus(wr_bus), .fc_bus(fc_bus),
    .fc_timeout(fc_timeout), .bus_error(bus_error), .err_addr(err_addr),
    .err_master(err_master), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  // Model: owner index (-1 = none), last winner, consecutive unanswered strobe cycles.
  int           m_own, m_last, m_run;
  logic [M-1:0] e_grant;
  logic         e_fc, e_err;
  logic [31:0]  e_addr;
  logic [1:0]   e_mst;

  task automatic model_reset();
    m_own = -1; m_last = M - 1; m_run = 0;
    e_grant = '0; e_fc = 1'b0; e_err = 1'b0; e_addr = 32'd0; e_mst = 2'd0;
  endtask

  task automatic model_edge();
    bit owned, strobe, fire, still;
    int prev, c;
    owned  = (m_own >= 0);
    prev   = m_own;
    strobe = rd_bus | wr_bus;
    fire   = owned && strobe && !fc_bus && (m_run + 1 == T);
    if (!owned) begin
      for (int k = 1; k <= M; k++) begin
        c = (m_last + k) % M;
        if (bus_req[c] && (m_own < 0)) begin
          m_own  = c;
          m_last = c;
        end
      end
    end else if (!bus_req[m_own]) begin
      m_own = -1;
    end
    still = owned && (m_own >= 0);
    m_run = (still && strobe && !fc_bus) ? m_run + 1 : 0;
    if (m_run > T) m_run = T;
    e_grant = '0;
    if (m_own >= 0) e_grant[m_own] = 1'b1;
    e_fc = fire;
    if (fire) begin
      e_err  = 1'b1;
      e_addr = addr_bus;
      e_mst  = 2'(prev);
    end else if (err_clr) begin
      e_err = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".grant"}, 32'(bus_grant), 32'(e_grant));
    chk({tag, ".fc_timeout"}, 32'(fc_timeout), 32'(e_fc));
    chk({tag, ".bus_error"}, 32'(bus_error), 32'(e_err));
    chk({tag, ".err_addr"}, err_addr, e_addr);
    chk({tag, ".err_master"}, 32'(err_master), 32'(e_mst));
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  int pulses;

  initial begin
    model_reset();
    // Reset held with both masters requesting.
    bus_req = 2'b11;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset");
    rst = 1'b1;
    tick("rst_release");
    chk("first_grant", 32'(bus_grant), 32'h1);

    // Round-robin with a dead cycle between owners.
    bus_req = 2'b10; tick("m0_drop");
    chk("dead_cycle0", 32'(bus_grant), 32'h0);
    bus_req = 2'b11; tick("rr_to_m1");
    chk("rr_m1", 32'(bus_grant), 32'h2);
    bus_req = 2'b01; tick("m1_drop");
    chk("dead_cycle1", 32'(bus_grant), 32'h0);
    bus_req = 2'b11; tick("rr_to_m0");
    chk("rr_m0", 32'(bus_grant), 32'h1);

    // No preemption: master 1 owns while master 0 requests.
    bus_req = 2'b00; tick("rel");
    bus_req = 2'b10; tick("m1_own");
    bus_req = 2'b11;
    repeat (20) tick("no_preempt");
    chk("still_m1", 32'(bus_grant), 32'h2);
    bus_req = 2'b01; tick("m1_rel");
    tick("m0_after");
    chk("m0_after_m1", 32'(bus_grant), 32'h1);

    // Normal read answered after 10 cycles.
    rd_bus = 1'b1; addr_bus = 32'h0000_0040;
    repeat (10) tick("normal_rd");
    fc_bus = 1'b1; tick("normal_fc");
    fc_bus = 1'b0; rd_bus = 1'b0; tick("normal_end");
    chk("normal_no_err", 32'(bus_error), 32'h0);

    // Timeout on a write from master 0, strobe then held 10 more cycles.
    wr_bus = 1'b1; addr_bus = 32'h8000_1000;
    pulses = 0;
    for (int i = 0; i < T + 10; i++) begin
      tick("timeout");
      pulses += int'(fc_timeout);
      if (i == T - 1) chk("pulse_at_T", 32'(fc_timeout), 32'h1);
    end
    chk("single_pulse", 32'(pulses), 32'h1);
    chk("err_set", 32'(bus_error), 32'h1);
    chk("err_addr_cap", err_addr, 32'h8000_1000);
    chk("err_master_cap", 32'(err_master), 32'h0);

    // Clear racing a new firing: firing wins, clear alone then works.
    wr_bus = 1'b0; tick("strobe_drop");
    wr_bus = 1'b1; addr_bus = 32'h8000_2000;
    repeat (T - 1) tick("race_pre");
    err_clr = 1'b1; tick("race_fire");
    chk("race_err_kept", 32'(bus_error), 32'h1);
    chk("race_pulse", 32'(fc_timeout), 32'h1);
    wr_bus = 1'b0; tick("clr_alone");
    chk("clr_works", 32'(bus_error), 32'h0);
    chk("addr_held", err_addr, 32'h8000_2000);
    err_clr = 1'b0;

    // Asynchronous reset while owned drops the grant without a clock edge.
    bus_req = 2'b11; tick("pre_async");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("async_grant_drop", 32'(bus_grant), 32'h0);
    model_reset();
    @(posedge clk); #1;
    chk_all("async_hold");
    rst = 1'b1;
    tick("async_release");

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < M; b++)
        if ($urandom_range(0, 29) == 0) bus_req[b] = ~bus_req[b];
      rd_bus   = ($urandom_range(0, 9) < 6);
      wr_bus   = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 39) == 0) begin
        rd_bus = 1'b0; wr_bus = 1'b0;
      end
      fc_bus   = ($urandom_range(0, 24) == 0);
      err_clr  = ($urandom_range(0, 19) == 0);
      addr_bus = $urandom;
      tick("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
